// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 geometry) and the capture FSM state type.
package vga_pkg;

   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_TOTAL  = VGA_H_SYNC + VGA_H_BP + VGA_H_ACTIVE + VGA_H_FP;

   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_TOTAL  = VGA_V_SYNC + VGA_V_BP + VGA_V_ACTIVE + VGA_V_FP;

   localparam int RGB_W  = 3;
   localparam int COL_W  = 11;
   localparam int LINE_W = 11;
   localparam int ADDR_W = 19;

   localparam logic [COL_W-1:0]  COL_MAX  = '1;
   localparam logic [LINE_W-1:0] LINE_MAX = '1;

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
   } cap_state_t;

endpackage

// File: rtl/vga_capture_if.sv
// Raw VGA video bus: active-low syncs plus one pixel of colour per clock.
interface vga_capture_if;
   import vga_pkg::*;

   logic             hs;
   logic             vs;
   logic [RGB_W-1:0] rgb;

   modport master (output hs, vs, rgb);
   modport slave  (input  hs, vs, rgb);

endinterface

// File: rtl/vga_capture_counter.sv
// Input register stage, sync edge detect and column/line counters; o_col/o_line describe the sample in o_rgb.
module vga_capture_counter
   import vga_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_hs,
   input  logic              i_vs,
   input  logic [RGB_W-1:0]  i_rgb,
   output logic [RGB_W-1:0]  o_rgb,
   output logic              o_hs_fall,
   output logic              o_vs_fall,
   output logic [COL_W-1:0]  o_col,
   output logic [COL_W-1:0]  o_col_prev,
   output logic [LINE_W-1:0] o_line,
   output logic [LINE_W-1:0] o_line_prev
);

   logic              r_hs;
   logic              r_hs_d;
   logic              r_vs;
   logic              r_vs_d;
   logic [RGB_W-1:0]  r_rgb;
   logic [COL_W-1:0]  r_col;
   logic [LINE_W-1:0] r_line;

   logic              w_hs_fall;
   logic              w_vs_fall;
   logic [COL_W-1:0]  w_col;
   logic [LINE_W-1:0] w_line;

   // Sync registers reset low so a sync already low at release is not seen as an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hs   <= 1'b0;
         r_hs_d <= 1'b0;
         r_vs   <= 1'b0;
         r_vs_d <= 1'b0;
         r_rgb  <= '0;
         r_col  <= '0;
         r_line <= '0;
      end else begin
         r_hs   <= i_hs;
         r_hs_d <= r_hs;
         r_vs   <= i_vs;
         r_vs_d <= r_vs;
         r_rgb  <= i_rgb;
         r_col  <= w_col;
         r_line <= w_line;
      end
   end

   assign w_hs_fall = r_hs_d & ~r_hs;
   assign w_vs_fall = r_vs_d & ~r_vs;

   always_comb begin
      w_col = (r_col == COL_MAX) ? COL_MAX : r_col + COL_W'(1);
      if (w_hs_fall) begin
         w_col = '0;
      end
      w_line = r_line;
      if (w_hs_fall && (r_line != LINE_MAX)) begin
         w_line = r_line + LINE_W'(1);
      end
      if (w_vs_fall) begin
         w_line = '0;
      end
   end

   assign o_rgb       = r_rgb;
   assign o_hs_fall   = w_hs_fall;
   assign o_vs_fall   = w_vs_fall;
   assign o_col       = w_col;
   assign o_col_prev  = r_col;
   assign o_line      = w_line;
   assign o_line_prev = r_line;

endmodule

// File: rtl/vga_capture.sv
// VGA capture: locks onto verified sync timing and streams active pixels with linear addresses, 2-clock latency, no backpressure.
// Defining VGA_CAPTURE_STATS_EN adds o_frame_count (completed frames since reset or last loss of lock).
module vga_capture
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int H_TOTAL  = VGA_H_TOTAL,
   parameter int V_TOTAL  = VGA_V_TOTAL,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BACK   = VGA_H_BP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BACK   = VGA_V_BP
)(
   input  logic              clk,
   input  logic              rst,
   vga_capture_if.slave      i_vid,
   output logic              o_pixel_valid,
   output logic [RGB_W-1:0]  o_pixel_data,
   output logic [ADDR_W-1:0] o_pixel_address,
   output logic              o_frame_done,
   output logic              o_locked,
   output logic              o_error
`ifdef VGA_CAPTURE_STATS_EN
   ,
   output logic [15:0]       o_frame_count
`endif
);

   localparam logic [COL_W-1:0]  H_FIRST   = COL_W'(H_SYNC + H_BACK);
   localparam logic [COL_W-1:0]  H_END     = COL_W'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [COL_W-1:0]  H_LAST    = COL_W'(H_TOTAL - 1);
   localparam logic [LINE_W-1:0] V_FIRST   = LINE_W'(V_SYNC + V_BACK);
   localparam logic [LINE_W-1:0] V_END     = LINE_W'(V_SYNC + V_BACK + V_ACTIVE);
   localparam logic [LINE_W-1:0] V_LAST    = LINE_W'(V_TOTAL - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

   logic [RGB_W-1:0]  w_rgb;
   logic              w_hs_fall;
   logic              w_vs_fall;
   logic [COL_W-1:0]  w_col;
   logic [COL_W-1:0]  w_col_prev;
   logic [LINE_W-1:0] w_line;
   logic [LINE_W-1:0] w_line_prev;

   logic              w_hs_bad;
   logic              w_vs_bad;
   logic              w_v_over;
   logic              w_fail;
   logic              w_active;
   logic              w_pix_ok;
   logic              w_frame_end;

   cap_state_t        r_state;
   logic              r_meas_bad;
   logic              r_locked;
   logic              r_error;
   logic              r_pix_vld;
   logic [RGB_W-1:0]  r_pix_dat;
   logic [ADDR_W-1:0] r_pix_addr;
   logic [ADDR_W-1:0] r_next_addr;
   logic              r_frame_done;

   vga_capture_counter u_counter (
      .clk         (clk),
      .rst         (rst),
      .i_hs        (i_vid.hs),
      .i_vs        (i_vid.vs),
      .i_rgb       (i_vid.rgb),
      .o_rgb       (w_rgb),
      .o_hs_fall   (w_hs_fall),
      .o_vs_fall   (w_vs_fall),
      .o_col       (w_col),
      .o_col_prev  (w_col_prev),
      .o_line      (w_line),
      .o_line_prev (w_line_prev)
   );

   // A line is wrong if Hs falls early, or if the column runs past the last clock with no fall.
   assign w_hs_bad = w_hs_fall ? (w_col_prev != H_LAST) : (w_col_prev == H_LAST);
   assign w_vs_bad = w_vs_fall && (w_line_prev != V_LAST);
   assign w_v_over = w_hs_fall && !w_vs_fall && (w_line_prev == V_LAST);

   always_comb begin
      w_fail = 1'b0;
      case (r_state)
         ST_MEASURE: w_fail = w_v_over | (w_vs_fall & (r_meas_bad | w_hs_bad | w_vs_bad));
         ST_LOCKED:  w_fail = w_hs_bad | w_vs_bad | w_v_over;
         default:    w_fail = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_SEARCH;
         r_meas_bad <= 1'b0;
         r_locked   <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_error <= w_fail;
         case (r_state)
            ST_SEARCH: begin
               r_locked <= 1'b0;
               if (w_vs_fall) begin
                  r_state    <= ST_MEASURE;
                  r_meas_bad <= 1'b0;
               end
            end
            ST_MEASURE: begin
               if (w_fail) begin
                  r_state  <= ST_SEARCH;
                  r_locked <= 1'b0;
               end else if (w_vs_fall) begin
                  r_state  <= ST_LOCKED;
                  r_locked <= 1'b1;
               end else if (w_hs_bad) begin
                  r_meas_bad <= 1'b1;
               end
            end
            ST_LOCKED: begin
               if (w_fail) begin
                  r_state  <= ST_SEARCH;
                  r_locked <= 1'b0;
               end
            end
            default: begin
               r_state  <= ST_SEARCH;
               r_locked <= 1'b0;
            end
         endcase
      end
   end

   assign w_active    = (w_col >= H_FIRST) && (w_col < H_END) &&
                        (w_line >= V_FIRST) && (w_line < V_END);
   // A violation detected on this sample already suppresses its pixel.
   assign w_pix_ok    = (r_state == ST_LOCKED) && !w_fail && w_active;
   assign w_frame_end = r_pix_vld && (r_pix_addr == ADDR_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pix_vld    <= 1'b0;
         r_pix_dat    <= '0;
         r_pix_addr   <= '0;
         r_next_addr  <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_pix_vld    <= w_pix_ok;
         r_frame_done <= w_frame_end;
         if (w_pix_ok) begin
            r_pix_dat  <= w_rgb;
            r_pix_addr <= r_next_addr;
            if (r_next_addr != ADDR_LAST) begin
               r_next_addr <= r_next_addr + ADDR_W'(1);
            end
         end
         if ((r_state != ST_LOCKED) || w_vs_fall) begin
            r_next_addr <= '0;
         end
      end
   end

`ifdef VGA_CAPTURE_STATS_EN
   logic [15:0] r_frame_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame_cnt <= '0;
      end else if (w_fail) begin
         r_frame_cnt <= '0;
      end else if (w_frame_end) begin
         r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign o_frame_count = r_frame_cnt;
`endif

   assign o_pixel_valid   = r_pix_vld;
   assign o_pixel_data    = r_pix_dat;
   assign o_pixel_address = r_pix_addr;
   assign o_frame_done    = r_frame_done;
   assign o_locked        = r_locked;
   assign o_error         = r_error;

endmodule

// File: tb/tb_vga_capture.sv
// Directed frame sequence with random pixel colours; expected pixels come from frame geometry arithmetic.
module tb_vga_capture;
   import vga_pkg::*;

   localparam int H_SYN = 4;
   localparam int H_BP  = 4;
   localparam int H_ACT = 16;
   localparam int H_FP  = 4;
   localparam int H_TOT = H_SYN + H_BP + H_ACT + H_FP;
   localparam int V_SYN = 2;
   localparam int V_BP  = 2;
   localparam int V_ACT = 6;
   localparam int V_FP  = 2;
   localparam int V_TOT = V_SYN + V_BP + V_ACT + V_FP;
   localparam int H_ST  = H_SYN + H_BP;
   localparam int V_ST  = V_SYN + V_BP;

   logic        clk;
   logic        rst;
   logic        pix_vld;
   logic [2:0]  pix_dat;
   logic [18:0] pix_addr;
   logic        frame_done;
   logic        locked;
   logic        err;
`ifdef VGA_CAPTURE_STATS_EN
   logic [15:0] frame_cnt;
`endif

   vga_capture_if vid ();

   vga_capture #(
      .H_ACTIVE (H_ACT), .V_ACTIVE (V_ACT), .H_TOTAL (H_TOT), .V_TOTAL (V_TOT),
      .H_SYNC   (H_SYN), .H_BACK   (H_BP),  .V_SYNC  (V_SYN), .V_BACK  (V_BP)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .i_vid           (vid),
      .o_pixel_valid   (pix_vld),
      .o_pixel_data    (pix_dat),
      .o_pixel_address (pix_addr),
      .o_frame_done    (frame_done),
      .o_locked        (locked),
      .o_error         (err)
`ifdef VGA_CAPTURE_STATS_EN
      ,
      .o_frame_count   (frame_cnt)
`endif
   );

   typedef struct packed {
      logic [18:0] addr;
      logic [2:0]  dat;
   } pix_t;

   pix_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_done   = 0;
   int   n_err    = 0;
   int   rst_left = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_vld"},    32'(pix_vld),    0);
      chk({pfx, "_dat"},    32'(pix_dat),    0);
      chk({pfx, "_addr"},   32'(pix_addr),   0);
      chk({pfx, "_done"},   32'(frame_done), 0);
      chk({pfx, "_locked"}, 32'(locked),     0);
      chk({pfx, "_error"},  32'(err),        0);
`ifdef VGA_CAPTURE_STATS_EN
      chk({pfx, "_count"},  32'(frame_cnt),  0);
`endif
   endtask

   // Every valid output pixel must be the oldest pixel the geometry says should be captured.
   always @(negedge clk) begin
      if (frame_done === 1'b1) n_done++;
      if (err === 1'b1) n_err++;
      if (pix_vld === 1'b1) begin
         chk("pix_pending", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            pix_t e;
            e = exp_q.pop_front();
            chk("pix_addr", 32'(pix_addr), 32'(e.addr));
            chk("pix_data", 32'(pix_dat),  32'(e.dat));
         end
      end
   end

   task automatic idle(input int n);
      vid.hs = 1'b1;
      vid.vs = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // cap: frame expected to be captured; short_v: line one clock short; rst_v/rst_h: reset point.
   task automatic drive_frame(input int n_lines, input int short_v, input bit cap, input bit pat,
                              input int rst_v, input int rst_h);
      for (int v = 0; v < n_lines; v++) begin
         int hlen;
         hlen = (v == short_v) ? H_TOT - 1 : H_TOT;
         for (int h = 0; h < hlen; h++) begin
            int         row, col, addr;
            bit         act, keep;
            logic [2:0] d;
            pix_t       p;
            row  = v - V_ST;
            col  = h - H_ST;
            addr = row * H_ACT + col;
            act  = (row >= 0) && (row < V_ACT) && (col >= 0) && (col < H_ACT);
            keep = ((short_v < 0) || (v <= short_v)) &&
                   ((rst_v < 0) || (v < rst_v) || ((v == rst_v) && (h <= rst_h - 2)));
            d = pat ? 3'(addr) : 3'($urandom);
            vid.hs  = (h < H_SYN) ? 1'b0 : 1'b1;
            vid.vs  = (v < V_SYN) ? 1'b0 : 1'b1;
            vid.rgb = d;
            if (cap && act && keep) begin
               p.addr = 19'(addr);
               p.dat  = d;
               exp_q.push_back(p);
            end
            @(posedge clk);
            #1;
            if ((v == rst_v) && (h == rst_h)) begin
               rst = 1'b1;
               #1;
               chk_zero("midrst");
               rst_left = 10;
            end else if (rst_left > 0) begin
               rst_left--;
               if (rst_left == 0) rst = 1'b0;
            end
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst     = 1'b1;
      vid.hs  = 1'b1;
      vid.vs  = 1'b1;
      vid.rgb = '0;
      repeat (10) @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b0;
      idle(5);

      // Measured frame, then locked at the second Vs fall.
      drive_frame(V_TOT, -1, 1'b0, 1'b0, -1, -1);
      chk("a_locked", 32'(locked), 0);
      chk("a_errors", n_err, 0);
      chk("a_q", exp_q.size(), 0);
      drive_frame(V_TOT, -1, 1'b1, 1'b0, -1, -1);
      chk("b_locked", 32'(locked), 1);
      chk("b_done", n_done, 1);
      chk("b_errors", n_err, 0);
      chk("b_q", exp_q.size(), 0);

      drive_frame(V_TOT, -1, 1'b1, 1'b1, -1, -1);
      chk("c_done", n_done, 2);
      chk("c_q", exp_q.size(), 0);
      drive_frame(V_TOT, -1, 1'b1, 1'b0, -1, -1);
      chk("d_done", n_done, 3);
`ifdef VGA_CAPTURE_STATS_EN
      chk("d_count", 32'(frame_cnt), 3);
`endif

      // One short line while locked: capture stops after that line.
      drive_frame(V_TOT, V_ST + 2, 1'b1, 1'b0, -1, -1);
      chk("e_errors", n_err, 1);
      chk("e_locked", 32'(locked), 0);
      chk("e_done", n_done, 3);
      chk("e_q", exp_q.size(), 0);
`ifdef VGA_CAPTURE_STATS_EN
      chk("e_count", 32'(frame_cnt), 0);
`endif
      drive_frame(V_TOT, -1, 1'b0, 1'b0, -1, -1);
      chk("f_locked", 32'(locked), 0);
      drive_frame(V_TOT, -1, 1'b1, 1'b1, -1, -1);
      chk("g_locked", 32'(locked), 1);
      chk("g_done", n_done, 4);
      chk("g_errors", n_err, 1);
      chk("g_q", exp_q.size(), 0);

      // Frame one line short: its pixels complete, the error lands at the next Vs fall.
      drive_frame(V_TOT - 1, -1, 1'b1, 1'b0, -1, -1);
      chk("h_done", n_done, 5);
      chk("h_locked", 32'(locked), 1);
`ifdef VGA_CAPTURE_STATS_EN
      chk("h_count", 32'(frame_cnt), 2);
`endif
      drive_frame(V_TOT, -1, 1'b0, 1'b0, -1, -1);
      chk("i_errors", n_err, 2);
      chk("i_locked", 32'(locked), 0);
      chk("i_q", exp_q.size(), 0);
`ifdef VGA_CAPTURE_STATS_EN
      chk("i_count", 32'(frame_cnt), 0);
`endif

      // Reset in the middle of an active line of a locked frame.
      drive_frame(V_TOT, -1, 1'b0, 1'b0, -1, -1);
      drive_frame(V_TOT, -1, 1'b1, 1'b0, V_ST + 3, H_ST + 8);
      chk("k_locked", 32'(locked), 0);
      chk("k_done", n_done, 5);
      chk("k_errors", n_err, 2);
      chk("k_q", exp_q.size(), 0);
      drive_frame(V_TOT, -1, 1'b0, 1'b0, -1, -1);
      chk("l_locked", 32'(locked), 0);
      drive_frame(V_TOT, -1, 1'b1, 1'b1, -1, -1);
      chk("m_locked", 32'(locked), 1);
      chk("m_done", n_done, 6);
      chk("m_q", exp_q.size(), 0);
`ifdef VGA_CAPTURE_STATS_EN
      chk("m_count", 32'(frame_cnt), 1);
`endif

      idle(4);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 SHALL have parameter H_TOTAL, default 800, clocks per line (sync 96, back porch 48, active, front porch 16).
REQ-004 SHALL have parameter V_TOTAL, default 525, lines per frame (sync 2, back porch 33, active, front porch 10).
REQ-005 Clock  input  1  pixel clock; all logic on rising edge.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 iHs  input  1  horizontal sync, active-low, synchronous to Clock.
REQ-008 iVs  input  1  vertical sync, active-low, synchronous to Clock.
REQ-009 iRGB  input  3  pixel colour, one pixel per Clock.
REQ-010 oPixelValid  output  1  oPixelData/oPixelAddress valid this cycle.
REQ-011 oPixelData  output  3  captured colour.
REQ-012 oPixelAddress  output  19  row*H_ACTIVE+col, 0..307199.
REQ-013 oFrameDone  output  1  one-cycle pulse after last active pixel of a locked frame.
REQ-014 oLocked  output  1  timing verified, capture enabled.
REQ-015 oError  output  1  one-cycle pulse on timing violation.

Function
REQ-016 Inputs SHALL be registered once; edges detected on the registered copies.
REQ-017 Hs falling edge SHALL clear column counter to 0; counter otherwise increments per Clock, saturating at 2047.
REQ-018 Hs falling edge SHALL increment line counter; Vs falling edge SHALL clear it to 0 (takes priority when both fall in the same cycle).
REQ-019 Active region: column 144..783, line 35..514 (sync+back porch offsets derived from parameters).
REQ-020 FSM states SEARCH, MEASURE, LOCKED; reset state SEARCH.
REQ-021 SEARCH -> MEASURE on first Vs falling edge.
REQ-022 MEASURE -> LOCKED on next Vs falling edge if every Hs period was exactly H_TOTAL and line count equals V_TOTAL; else -> SEARCH with oError pulse.
REQ-023 LOCKED: any Hs period != H_TOTAL, or Vs fall with line count != V_TOTAL, or line count reaching V_TOTAL+1 without Vs fall -> SEARCH, oError pulse, oLocked low next cycle.
REQ-024 oPixelValid SHALL assert only in LOCKED and active region; latency 2 cycles from iRGB at pins to oPixelData.
REQ-025 oPixelAddress SHALL be computed incrementally (no multiplier): 0 at first active pixel of frame, +1 per valid pixel, no wrap inside frame.
REQ-026 oFrameDone SHALL pulse the cycle after the valid pixel with address 307199.
REQ-027 Timing loss mid-line SHALL drop oPixelValid immediately; partial frame yields no oFrameDone.

Reset
REQ-028 Reset SHALL force: FSM SEARCH, counters 0, oPixelValid 0, oPixelData 0, oPixelAddress 0, oFrameDone 0, oLocked 0, oError 0.
REQ-029 Reset deassertion mid-frame SHALL require full SEARCH/MEASURE before capture resumes.

Configuration
REQ-030 With VGA_CAPTURE_STATS_EN defined, SHALL add output oFrameCount (16 bits), incremented on each oFrameDone, wraps 65535->0, cleared by Reset and on entry to SEARCH.
REQ-031 Without VGA_CAPTURE_STATS_EN, port and counter SHALL be absent.

Structure
REQ-032 Timing constants (sync widths, porches, totals) and FSM state enum SHALL live in shared package vga_pkg, also used by the VGA generator.
REQ-033 Column/line counters and edge detection SHALL be sub-module vga_capture_counter; FSM and address path in top.

Verification
REQ-034 Reset pulse 100 ns, then drive two nominal frames from the VGA generator -> oLocked rises at second Vs fall, 0 errors.
REQ-035 Third frame with iRGB = address[2:0] pattern -> 307200 valid pixels, data matches, addresses 0..307199 sequential, one oFrameDone.
REQ-036 Shorten one Hs period to 799 while LOCKED -> oError pulse, oLocked low, no oFrameDone that frame, relock after two clean frames.
REQ-037 Frame with 524 lines -> oError at Vs fall, state SEARCH.
REQ-038 Assert Reset mid-active line 200 -> all outputs 0 next cycle; capture resumes only after MEASURE frame.
REQ-039 With VGA_CAPTURE_STATS_EN, run 3 locked frames -> oFrameCount = 3; force error -> 0.
